// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The slave modport is the controller; the master modport is the datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             pc_write_cond_o;
  logic [1:0]       pc_source_o;
  logic             iord_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             ir_write_o;
  logic             mem_to_reg_o;
  logic             reg_dst_o;
  logic             reg_write_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [2:0]       alu_op_o;
  logic [3:0]       state_o;
  logic             illegal_o;
  logic             timeout_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    output opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, pc_source_o, iord_o, mem_read_o,
           mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, illegal_o,
           timeout_o, retired_o
  );

  modport slave (
    input  opcode_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, pc_source_o, iord_o, mem_read_o,
           mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, illegal_o,
           timeout_o, retired_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: Moore-decoded datapath controls per state,
// memory-ready stalls with a bounded wait, retired-instruction count, sticky halt causes.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10,
    HALT      = 4'd11
  } state_t;

  localparam int NUM_STATES = 12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMSH = 2'b11;

  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  // States that finish an instruction on their way back to FETCH.
  localparam logic [NUM_STATES-1:0] RETIRE_MASK =
      (NUM_STATES'(1) << MEM_WB) | (NUM_STATES'(1) << MEM_WRITE) |
      (NUM_STATES'(1) << R_WB)   | (NUM_STATES'(1) << BRANCH)    |
      (NUM_STATES'(1) << I_WB);

  // States that stall on the memory handshake and run the wait counter.
  localparam logic [NUM_STATES-1:0] WAIT_MASK =
      (NUM_STATES'(1) << FETCH) | (NUM_STATES'(1) << MEM_READ) |
      (NUM_STATES'(1) << MEM_WRITE);

  state_t           state_reg;
  state_t           state_next;
  logic [7:0]       wait_cnt_reg;
  logic [7:0]       wait_cnt_next;
  logic             illegal_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] retired_reg;

  logic set_illegal;
  logic set_timeout;
  logic retire;
  logic in_wait_state;
  logic in_retire_state;

  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;

  logic [NUM_STATES-1:0] state_hot;

  generate
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_state_hot
      assign state_hot[gi] = (state_reg == state_t'(gi));
    end
  endgenerate

  assign in_wait_state   = |(state_hot & WAIT_MASK);
  assign in_retire_state = |(state_hot & RETIRE_MASK);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (set_illegal) begin
        illegal_reg <= 1'b1;
      end
      if (set_timeout) begin
        timeout_reg <= 1'b1;
      end
      if (retire) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;

    unique case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_write  = bus.mem_ready_i;
        ir_write  = bus.mem_ready_i;
        if (bus.mem_ready_i) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Branch target is precomputed here so BRANCH can compare and select.
        alu_src_b = SRC_B_IMMSH;
        unique case (bus.opcode_i)
          OP_RTYPE:       state_next = R_EXEC;
          OP_LW, OP_SW:   state_next = MEM_ADDR;
          OP_BEQ:         state_next = BRANCH;
          OP_ADDI, OP_SLTI: state_next = I_EXEC;
          default: begin
            state_next  = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        state_next = (bus.opcode_i == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready_i) begin
          state_next = MEM_WB;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready_i) begin
          state_next = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        state_next = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_next    = FETCH;
      end
      I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = (bus.opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_next = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = HALT;
      end
    endcase

    // Leaving a stall state or seeing ready clears the counter; a ready on
    // the limit cycle still advances normally.
    if (in_wait_state && !bus.mem_ready_i) begin
      if (wait_cnt_reg == WAIT_MAX) begin
        state_next  = HALT;
        set_timeout = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt_reg + 8'd1;
      end
    end

    retire = in_retire_state && (state_next == FETCH);
  end

  // Write strobes are blocked combinationally while reset is held.
  assign bus.pc_write_o      = pc_write  & ~rst_i;
  assign bus.ir_write_o      = ir_write  & ~rst_i;
  assign bus.reg_write_o     = reg_write & ~rst_i;
  assign bus.mem_write_o     = mem_write & ~rst_i;
  assign bus.pc_write_cond_o = pc_write_cond;
  assign bus.pc_source_o     = pc_source;
  assign bus.iord_o          = iord;
  assign bus.mem_read_o      = mem_read;
  assign bus.mem_to_reg_o    = mem_to_reg;
  assign bus.reg_dst_o       = reg_dst;
  assign bus.alu_src_a_o     = alu_src_a;
  assign bus.alu_src_b_o     = alu_src_b;
  assign bus.alu_op_o        = alu_op;
  assign bus.state_o         = state_reg;
  assign bus.illegal_o       = illegal_reg;
  assign bus.timeout_o       = timeout_reg;
  assign bus.retired_o       = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a vector table of per-cycle expectations
// plus hand-written stall, timeout, illegal-opcode and async-reset sequences.
module tb_multicycle_ctrl;

  localparam int WL    = 15;
  localparam int CNT_W = 32;

  // Packed control word: {pc_write, pc_write_cond, pc_source[1:0], iord, mem_read,
  // mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[2:0]}
  localparam logic [16:0] C_F1  = 17'b1_0_00_0_1_0_1_0_0_0_0_01_000;
  localparam logic [16:0] C_F0  = 17'b0_0_00_0_1_0_0_0_0_0_0_01_000;
  localparam logic [16:0] C_DEC = 17'b0_0_00_0_0_0_0_0_0_0_0_11_000;
  localparam logic [16:0] C_MA  = 17'b0_0_00_0_0_0_0_0_0_0_1_10_000;
  localparam logic [16:0] C_MR  = 17'b0_0_00_1_1_0_0_0_0_0_0_00_000;
  localparam logic [16:0] C_MWB = 17'b0_0_00_0_0_0_0_1_0_1_0_00_000;
  localparam logic [16:0] C_MW  = 17'b0_0_00_1_0_1_0_0_0_0_0_00_000;
  localparam logic [16:0] C_RE  = 17'b0_0_00_0_0_0_0_0_0_0_1_00_010;
  localparam logic [16:0] C_RWB = 17'b0_0_00_0_0_0_0_0_1_1_0_00_000;
  localparam logic [16:0] C_BR  = 17'b0_1_01_0_0_0_0_0_0_0_1_00_001;
  localparam logic [16:0] C_IA  = 17'b0_0_00_0_0_0_0_0_0_0_1_10_000;
  localparam logic [16:0] C_IS  = 17'b0_0_00_0_0_0_0_0_0_0_1_10_011;
  localparam logic [16:0] C_IWB = 17'b0_0_00_0_0_0_0_0_0_1_0_00_000;
  localparam logic [16:0] C_HLT = 17'b0;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    int          ret;
    logic [1:0]  flags;   // {illegal, timeout}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[37];

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ctl_word();
    return {bus.pc_write_o, bus.pc_write_cond_o, bus.pc_source_o, bus.iord_o,
            bus.mem_read_o, bus.mem_write_o, bus.ir_write_o, bus.mem_to_reg_o,
            bus.reg_dst_o, bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
            bus.alu_op_o};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                              input logic [16:0] ctl, input int ret, input logic [1:0] fl);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.ret = ret; v.flags = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the negedge, check the settled outputs, move to next negedge.
  task automatic run_vec(input vec_t v, input string tag);
    bus.opcode_i    = v.op;
    bus.mem_ready_i = v.rdy;
    #1;
    $display("[%0t] %s op=%h rdy=%b state=%0d ctl=%h retired=%0d ill=%b to=%b",
             $time, tag, v.op, v.rdy, bus.state_o, ctl_word(), bus.retired_o,
             bus.illegal_o, bus.timeout_o);
    chk({tag, " state"},   64'(bus.state_o), 64'(v.st));
    chk({tag, " ctl"},     64'(ctl_word()), 64'(v.ctl));
    chk({tag, " retired"}, 64'(bus.retired_o), 64'(v.ret));
    chk({tag, " flags"},   64'({bus.illegal_o, bus.timeout_o}), 64'(v.flags));
    @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      run_vec(tbl[i], $sformatf("row%0d", i));
    end
  endtask

  // Assert reset with ready high: write strobes must stay low, other outputs at FETCH values.
  task automatic do_reset(input string tag);
    rst             = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.opcode_i    = 6'h00;
    #1;
    $display("[%0t] %s reset state=%0d ctl=%h retired=%0d", $time, tag,
             bus.state_o, ctl_word(), bus.retired_o);
    chk({tag, " rst state"},   64'(bus.state_o), 64'd0);
    chk({tag, " rst ctl"},     64'(ctl_word()), 64'(C_F0));
    chk({tag, " rst retired"}, 64'(bus.retired_o), 64'd0);
    chk({tag, " rst flags"},   64'({bus.illegal_o, bus.timeout_o}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk({tag, " rst held state"}, 64'(bus.state_o), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // lw, R-type, sw, beq, addi, slti, then a stalled fetch of another lw
    tbl[0]  = mk(6'h23, 1, 0,  C_F1,  0, 2'b00);
    tbl[1]  = mk(6'h23, 1, 1,  C_DEC, 0, 2'b00);
    tbl[2]  = mk(6'h23, 1, 2,  C_MA,  0, 2'b00);
    tbl[3]  = mk(6'h23, 1, 3,  C_MR,  0, 2'b00);
    tbl[4]  = mk(6'h23, 1, 4,  C_MWB, 0, 2'b00);
    tbl[5]  = mk(6'h00, 1, 0,  C_F1,  1, 2'b00);
    tbl[6]  = mk(6'h00, 1, 1,  C_DEC, 1, 2'b00);
    tbl[7]  = mk(6'h00, 1, 6,  C_RE,  1, 2'b00);
    tbl[8]  = mk(6'h00, 1, 7,  C_RWB, 1, 2'b00);
    tbl[9]  = mk(6'h2B, 1, 0,  C_F1,  2, 2'b00);
    tbl[10] = mk(6'h2B, 1, 1,  C_DEC, 2, 2'b00);
    tbl[11] = mk(6'h2B, 1, 2,  C_MA,  2, 2'b00);
    tbl[12] = mk(6'h2B, 1, 5,  C_MW,  2, 2'b00);
    tbl[13] = mk(6'h04, 1, 0,  C_F1,  3, 2'b00);
    tbl[14] = mk(6'h04, 1, 1,  C_DEC, 3, 2'b00);
    tbl[15] = mk(6'h04, 1, 8,  C_BR,  3, 2'b00);
    tbl[16] = mk(6'h08, 1, 0,  C_F1,  4, 2'b00);
    tbl[17] = mk(6'h08, 1, 1,  C_DEC, 4, 2'b00);
    tbl[18] = mk(6'h08, 1, 9,  C_IA,  4, 2'b00);
    tbl[19] = mk(6'h08, 1, 10, C_IWB, 4, 2'b00);
    tbl[20] = mk(6'h0A, 1, 0,  C_F1,  5, 2'b00);
    tbl[21] = mk(6'h0A, 1, 1,  C_DEC, 5, 2'b00);
    tbl[22] = mk(6'h0A, 1, 9,  C_IS,  5, 2'b00);
    tbl[23] = mk(6'h0A, 1, 10, C_IWB, 5, 2'b00);
    tbl[24] = mk(6'h23, 0, 0,  C_F0,  6, 2'b00);
    tbl[25] = mk(6'h23, 0, 0,  C_F0,  6, 2'b00);
    tbl[26] = mk(6'h23, 0, 0,  C_F0,  6, 2'b00);
    tbl[27] = mk(6'h23, 1, 0,  C_F1,  6, 2'b00);
    tbl[28] = mk(6'h23, 1, 1,  C_DEC, 6, 2'b00);
    tbl[29] = mk(6'h23, 1, 2,  C_MA,  6, 2'b00);
    // beq then an illegal opcode
    tbl[30] = mk(6'h04, 1, 0,  C_F1,  0, 2'b00);
    tbl[31] = mk(6'h04, 1, 1,  C_DEC, 0, 2'b00);
    tbl[32] = mk(6'h04, 1, 8,  C_BR,  0, 2'b00);
    tbl[33] = mk(6'h3F, 1, 0,  C_F1,  1, 2'b00);
    tbl[34] = mk(6'h3F, 1, 1,  C_DEC, 1, 2'b00);
    tbl[35] = mk(6'h3F, 1, 11, C_HLT, 1, 2'b10);
    tbl[36] = mk(6'h3F, 0, 11, C_HLT, 1, 2'b10);

    bus.opcode_i    = 6'h00;
    bus.mem_ready_i = 1'b0;

    // Instruction mix, then MEM_READ starved for WL+1 cycles -> timeout halt.
    do_reset("A");
    run_rows(0, 29);
    for (int i = 0; i <= WL; i++) begin
      run_vec(mk(6'h23, 0, 3, C_MR, 6, 2'b00), $sformatf("mr_wait%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      run_vec(mk(6'h23, 1, 11, C_HLT, 6, 2'b01), $sformatf("to_halt%0d", i));
    end

    // Fetch starved for exactly WL cycles, ready arrives on the limit cycle: no timeout.
    do_reset("B");
    for (int i = 0; i < WL; i++) begin
      run_vec(mk(6'h00, 0, 0, C_F0, 0, 2'b00), $sformatf("f_wait%0d", i));
    end
    run_vec(mk(6'h00, 1, 0,  C_F1,  0, 2'b00), "f_limit_ready");
    run_vec(mk(6'h00, 1, 1,  C_DEC, 0, 2'b00), "b_dec");
    run_vec(mk(6'h00, 1, 6,  C_RE,  0, 2'b00), "b_rexec");
    run_vec(mk(6'h00, 1, 7,  C_RWB, 0, 2'b00), "b_rwb");
    run_vec(mk(6'h2B, 1, 0,  C_F1,  1, 2'b00), "b_fetch_sw");
    run_vec(mk(6'h2B, 1, 1,  C_DEC, 1, 2'b00), "b_dec_sw");
    run_vec(mk(6'h2B, 1, 2,  C_MA,  1, 2'b00), "b_maddr_sw");

    // In MEM_WRITE with ready low, raise reset between edges and check before the next edge.
    bus.mem_ready_i = 1'b0;
    #1;
    chk("mw_before_rst state", 64'(bus.state_o), 64'd5);
    chk("mw_before_rst mem_write", 64'(bus.mem_write_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("[%0t] async reset in MEM_WRITE state=%0d mem_write=%b retired=%0d",
             $time, bus.state_o, bus.mem_write_o, bus.retired_o);
    chk("async_rst state",     64'(bus.state_o), 64'd0);
    chk("async_rst mem_write", 64'(bus.mem_write_o), 64'd0);
    chk("async_rst retired",   64'(bus.retired_o), 64'd0);
    chk("async_rst flags",     64'({bus.illegal_o, bus.timeout_o}), 64'd0);
    @(negedge clk);
    do_reset("C");
    run_rows(30, 36);

    // Sticky illegal flag must clear on reset.
    do_reset("D");
    run_vec(mk(6'h00, 0, 0, C_F0, 0, 2'b00), "d_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
